// File: rtl/mmio_driver_if.sv
// MMIO request/response bus between the PSL-side initiator (master) and the
// AFU MMIO responder (slave). Bit 0 is the most significant bit.
interface mmio_driver_if;
    logic        ha_mmval;
    logic        ha_mmcfg;
    logic        ha_mmrnw;
    logic        ha_mmdw;
    logic [0:23] ha_mmad;
    logic        ha_mmadpar;
    logic [0:63] ha_mmdata;
    logic        ha_mmdatapar;
    logic        ah_mmack;
    logic [0:63] ah_mmdata;
    logic        ah_mmdatapar;

    modport master (
        output ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw, ha_mmad, ha_mmadpar,
               ha_mmdata, ha_mmdatapar,
        input  ah_mmack, ah_mmdata, ah_mmdatapar
    );

    modport slave (
        input  ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw, ha_mmad, ha_mmadpar,
               ha_mmdata, ha_mmdatapar,
        output ah_mmack, ah_mmdata, ah_mmdatapar
    );
endinterface

// File: rtl/mmio_driver.sv
// PSL-side MMIO initiator: one valid/ready command becomes one MMIO transaction
// with ack timeout and spurious-ack detection. Define MMIO_PARITY_CHECK_EN to
// build the read-data parity check (rsp_parerr); otherwise rsp_parerr is tied 0.
module mmio_driver #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic        ha_pclock,
    input  logic        ha_preset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_cfg,
    input  logic        cmd_rnw,
    input  logic        cmd_dw,
    input  logic [0:23] cmd_addr,
    input  logic [0:63] cmd_wdata,
    mmio_driver_if.master mm,
    output logic        rsp_valid,
    output logic [0:63] rsp_data,
    output logic        rsp_timeout,
    output logic        rsp_parerr,
    output logic        spurious_ack
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             cfg_q, rnw_q, dw_q;
    logic [0:23]      ad_q;
    logic [0:63]      wdata_q;
    logic [0:63]      rdata_q;
    logic             timeout_q, parerr_q, spurious_q;
    logic             accept, ack_hit, time_up, par_bad;

    assign accept  = (state == IDLE) && cmd_valid;
    assign ack_hit = (state == WAIT) && mm.ah_mmack;
    // An ack on the limit cycle takes priority over the timeout.
    assign time_up = (state == WAIT) && !mm.ah_mmack &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MMIO_PARITY_CHECK_EN
    assign par_bad = (mm.ah_mmdatapar != (^mm.ah_mmdata));
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
        if (!ha_preset_n) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (ack_hit || time_up) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
        if (!ha_preset_n)        wait_cnt <= '0;
        else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
        else                     wait_cnt <= '0;
    end

    // Word writes replicate the low word into both halves of the data bus.
    always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
        if (!ha_preset_n) begin
            cfg_q   <= 1'b0;
            rnw_q   <= 1'b0;
            dw_q    <= 1'b0;
            ad_q    <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            cfg_q   <= cmd_cfg;
            rnw_q   <= cmd_rnw;
            dw_q    <= cmd_dw;
            ad_q    <= cmd_addr;
            wdata_q <= cmd_rnw ? 64'd0 :
                       (cmd_dw ? cmd_wdata : {cmd_wdata[32:63], cmd_wdata[32:63]});
        end else if (state == RESP) begin
            cfg_q   <= 1'b0;
            rnw_q   <= 1'b0;
            dw_q    <= 1'b0;
            ad_q    <= '0;
            wdata_q <= '0;
        end
    end

    always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
        if (!ha_preset_n) begin
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            parerr_q  <= 1'b0;
        end else if (state == ISSUE) begin
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            parerr_q  <= 1'b0;
        end else if (ack_hit) begin
            rdata_q   <= rnw_q ? mm.ah_mmdata : 64'd0;
            timeout_q <= 1'b0;
            parerr_q  <= rnw_q & par_bad;
        end else if (time_up) begin
            rdata_q   <= '0;
            timeout_q <= 1'b1;
            parerr_q  <= 1'b0;
        end
    end

    always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
        if (!ha_preset_n) spurious_q <= 1'b0;
        else              spurious_q <= spurious_q | (mm.ah_mmack && (state != WAIT));
    end

    assign cmd_ready       = (state == IDLE) && ha_preset_n;
    assign mm.ha_mmval     = (state == ISSUE);
    assign mm.ha_mmcfg     = cfg_q;
    assign mm.ha_mmrnw     = rnw_q;
    assign mm.ha_mmdw      = dw_q;
    assign mm.ha_mmad      = ad_q;
    assign mm.ha_mmadpar   = ^ad_q;
    assign mm.ha_mmdata    = wdata_q;
    assign mm.ha_mmdatapar = ^wdata_q;

    assign rsp_valid    = (state == RESP);
    assign rsp_data     = rsp_valid ? rdata_q : 64'd0;
    assign rsp_timeout  = rsp_valid & timeout_q;
    assign rsp_parerr   = rsp_valid & parerr_q;
    assign spurious_ack = spurious_q;

endmodule

// File: tb/tb_mmio_driver.sv
// Self-checking bench for mmio_driver: a responder model acks 3 cycles after
// ha_mmval, and a scoreboard queue holds the expected response of each command.
module tb_mmio_driver;

    localparam int TIMEOUT = 8;
`ifdef MMIO_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [63:0] data;
        logic        timeout;
        logic        parerr;
        int          latency;
    } exp_t;

    logic        ha_pclock, ha_preset_n;
    logic        cmd_valid, cmd_ready, cmd_cfg, cmd_rnw, cmd_dw;
    logic [23:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic        rsp_valid, rsp_timeout, rsp_parerr, spurious_ack;
    logic [63:0] rsp_data;

    mmio_driver_if bus();

    mmio_driver #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(16)) dut (
        .ha_pclock   (ha_pclock),
        .ha_preset_n (ha_preset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_cfg     (cmd_cfg),
        .cmd_rnw     (cmd_rnw),
        .cmd_dw      (cmd_dw),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .mm          (bus),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .rsp_parerr  (rsp_parerr),
        .spurious_ack(spurious_ack)
    );

    int checksTotal  = 0;
    int checksPassed = 0;
    exp_t expQ[$];

    logic [63:0] respData   = '0;
    logic        respPar    = 1'b0;
    logic        respEnable = 1'b1;
    logic        forceAck   = 1'b0;
    int          ackCountdown = 0;

    int cycle = 0;
    int lastMmvalCycle = 0;
    int lastRspCycle = 0;
    int mmvalPulses = 0;
    int rspCount = 0;
    logic mmvalPrev = 1'b0;

    initial ha_pclock = 1'b0;
    always #5 ha_pclock = ~ha_pclock;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
    endtask

    task automatic tick();
        @(posedge ha_pclock);
        #3;
    endtask

    function automatic exp_t makeExp(input logic rnw, input logic [63:0] rdata,
                                     input logic rpar, input logic ackOn);
        exp_t e;
        if (!ackOn) begin
            e.data = '0; e.timeout = 1'b1; e.parerr = 1'b0; e.latency = TIMEOUT + 1;
        end else begin
            e.data    = rnw ? rdata : 64'd0;
            e.timeout = 1'b0;
            e.parerr  = PAR_EN && rnw && (rpar != (^rdata));
            e.latency = 4;
        end
        return e;
    endfunction

    // Responder model: ack three cycles after the request strobe.
    initial begin
        bus.ah_mmack = 1'b0;
        bus.ah_mmdata = '0;
        bus.ah_mmdatapar = 1'b0;
        forever begin
            @(posedge ha_pclock);
            #2;
            bus.ah_mmack = 1'b0;
            if (forceAck) begin
                bus.ah_mmack = 1'b1;
                forceAck = 1'b0;
            end
            if (ackCountdown > 0) begin
                ackCountdown--;
                if (ackCountdown == 0) begin
                    bus.ah_mmack = 1'b1;
                    bus.ah_mmdata = respData;
                    bus.ah_mmdatapar = respPar;
                end
            end
            if (bus.ha_mmval && respEnable) ackCountdown = 3;
        end
    end

    // Monitor: strobe width, and scoreboard pop on every response.
    initial begin
        exp_t e;
        forever begin
            @(posedge ha_pclock);
            cycle++;
            #1;
            if (mmvalPrev) checkOutput("mmval_one_cycle", bus.ha_mmval, 1'b0);
            if (bus.ha_mmval) begin
                lastMmvalCycle = cycle;
                mmvalPulses++;
            end
            mmvalPrev = bus.ha_mmval;
            if (rsp_valid) begin
                rspCount++;
                lastRspCycle = cycle;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rsp_data", rsp_data, e.data);
                    checkOutput("rsp_timeout", rsp_timeout, e.timeout);
                    checkOutput("rsp_parerr", rsp_parerr, e.parerr);
                    checkOutput("rsp_latency", cycle - lastMmvalCycle, e.latency);
                end
            end
        end
    end

    task automatic waitResponse(input int budget);
        int start = rspCount;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rspCount != start) break;
        end
        checkOutput("rsp_arrived", rspCount != start, 1'b1);
    endtask

    task automatic applyStimulus(input logic cfg, input logic rnw, input logic dw,
                                 input logic [23:0] addr, input logic [63:0] wdata,
                                 input logic [63:0] rdata, input logic rpar,
                                 input logic ackOn, input logic expectRsp);
        logic [63:0] expData;
        respData = rdata;
        respPar = rpar;
        respEnable = ackOn;
        if (expectRsp) expQ.push_back(makeExp(rnw, rdata, rpar, ackOn));
        expData = rnw ? 64'd0 : (dw ? wdata : {wdata[31:0], wdata[31:0]});
        cmd_cfg = cfg; cmd_rnw = rnw; cmd_dw = dw; cmd_addr = addr; cmd_wdata = wdata;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) break;
            tick();
        end
        checkOutput("cmd_ready_wait", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        checkOutput("mmval", bus.ha_mmval, 1'b1);
        checkOutput("mm_fields", {bus.ha_mmcfg, bus.ha_mmrnw, bus.ha_mmdw}, {cfg, rnw, dw});
        checkOutput("mmad", bus.ha_mmad, addr);
        checkOutput("mmadpar", bus.ha_mmadpar, ^addr);
        checkOutput("mmdata", bus.ha_mmdata, expData);
        checkOutput("mmdatapar", bus.ha_mmdatapar, ^expData);
    endtask

    initial begin
        int startPulses;
        ha_preset_n = 1'b0;
        cmd_valid = 1'b0; cmd_cfg = 1'b0; cmd_rnw = 1'b0; cmd_dw = 1'b0;
        cmd_addr = '0; cmd_wdata = '0;
        tick(); tick();
        checkOutput("reset_cmd_ready", cmd_ready, 1'b0);
        checkOutput("reset_outputs", {bus.ha_mmval, rsp_valid, spurious_ack, bus.ha_mmadpar}, 4'b0);
        ha_preset_n = 1'b1;
        tick();
        checkOutput("release_cmd_ready", cmd_ready, 1'b1);

        applyStimulus(1'b1, 1'b1, 1'b1, 24'h000000, 64'd0, 64'h0000000100010010, 1'b1, 1'b1, 1'b1);
        waitResponse(20);
        tick();

        applyStimulus(1'b0, 1'b0, 1'b0, 24'h000004, 64'h00000000DEADBEEF, 64'h0, 1'b0, 1'b1, 1'b1);
        tick(); tick();
        checkOutput("wdata_held", bus.ha_mmdata, 64'hDEADBEEFDEADBEEF);
        checkOutput("wdatapar_held", bus.ha_mmdatapar, 1'b0);
        waitResponse(20);
        tick();
        checkOutput("idle_cleared", bus.ha_mmdata, 64'd0);

        applyStimulus(1'b0, 1'b1, 1'b1, 24'h000010, 64'd0, 64'h0, 1'b0, 1'b0, 1'b1);
        waitResponse(30);
        checkOutput("spurious_before", spurious_ack, 1'b0);
        forceAck = 1'b1;
        tick(); tick();
        checkOutput("spurious_late_ack", spurious_ack, 1'b1);

        applyStimulus(1'b0, 1'b1, 1'b1, 24'h000020, 64'd0, 64'h1, 1'b0, 1'b1, 1'b1);
        waitResponse(20);
        tick();

        applyStimulus(1'b0, 1'b1, 1'b1, 24'h000007, 64'd0, 64'h55, 1'b0, 1'b1, 1'b0);
        tick();
        ha_preset_n = 1'b0;
        ackCountdown = 0;
        #1;
        checkOutput("midreset_outputs",
                    {bus.ha_mmval, rsp_valid, spurious_ack, cmd_ready, bus.ha_mmadpar}, 5'b0);
        checkOutput("midreset_addr", bus.ha_mmad, 24'h0);
        tick(); tick();
        ha_preset_n = 1'b1;
        tick();
        checkOutput("post_reset_ready", cmd_ready, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 24'h000008, 64'd0, 64'hCAFE0000BEEF0001, 1'b1, 1'b1, 1'b1);
        waitResponse(20);
        tick();

        // Back-to-back: cmd_valid held high across two transactions.
        respEnable = 1'b1;
        respData = 64'h0123456789ABCDEF;
        respPar = ^respData;
        expQ.push_back(makeExp(1'b1, respData, respPar, 1'b1));
        expQ.push_back(makeExp(1'b1, respData, respPar, 1'b1));
        cmd_cfg = 1'b0; cmd_rnw = 1'b1; cmd_dw = 1'b1; cmd_addr = 24'h000100; cmd_wdata = '0;
        startPulses = mmvalPulses;
        cmd_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mmvalPulses >= startPulses + 2) break;
        end
        cmd_valid = 1'b0;
        checkOutput("b2b_second_issue", mmvalPulses - startPulses, 2);
        checkOutput("b2b_gap", lastMmvalCycle - lastRspCycle, 2);
        waitResponse(20);

        tick(); tick(); tick();
        checkOutput("scoreboard_empty", expQ.size(), 0);
        checkOutput("spurious_final", spurious_ack, 1'b0);
        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
